// File: rtl/fir_requant_gain.sv
// Requantiser and per-band gain stage: rounds the FIR result to OW bits, applies a Q4.12 gain
// with saturation, counts saturated samples. Optional envelope tracker enabled by ENVELOPE_EN.
module fir_requant_gain #(
    parameter int IW      = 32,
    parameter int OW      = 16,
    parameter int SHIFT   = 15,
    parameter int GF      = 12,
    parameter int ENV_ATK = 2,
    parameter int ENV_REL = 6
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_valid,
    input  logic [IW-1:0] i_result,
    input  logic [15:0]   i_gain,
    input  logic          i_clr_sat,
    output logic          o_valid,
    output logic [OW-1:0] o_sample,
    output logic          o_sat,
    output logic [15:0]   o_sat_count,
    output logic [OW-1:0] o_env
);

    localparam int RW = IW + 1 - SHIFT;
    localparam int PW = OW + 17;
    localparam int QW = PW - GF;
    localparam logic [IW:0]   RND1 = (IW+1)'(1) << (SHIFT - 1);
    localparam logic [PW-1:0] RND2 = PW'(1) << (GF - 1);
    localparam logic [OW-1:0] MAXV = {1'b0, {(OW-1){1'b1}}};
    localparam logic [OW-1:0] MINV = {1'b1, {(OW-1){1'b0}}};

    logic          r_v1, r_v2, r_sat1;
    logic [RW-1:0] r_r1;
    logic [OW-1:0] r_s2;
    logic [15:0]   r_gain1, r_gain2;
    logic          r_valid, r_sat;
    logic [OW-1:0] r_sample;
    logic [15:0]   r_cnt;

    logic [IW:0]      w_rnd;
    logic [RW-1:0]    w_r1;
    logic [RW-OW:0]   w_hi1;
    logic             w_ovf1;
    logic [OW-1:0]    w_s2;
    logic [PW-1:0]    w_s2x, w_gx, w_p, w_pr;
    logic [QW-1:0]    w_qf;
    logic [QW-OW:0]   w_hi2;
    logic             w_ovf2;
    logic [OW-1:0]    w_q;
    logic             w_sat;

    // Sign-extend one bit before adding the rounding constant so it cannot wrap.
    assign w_rnd  = {i_result[IW-1], i_result} + RND1;
    assign w_r1   = w_rnd[IW:SHIFT];

    // A value fits OW bits exactly when all bits from the OW-1 sign position upward agree.
    assign w_hi1  = r_r1[RW-1:OW-1];
    assign w_ovf1 = !((&w_hi1) || (~|w_hi1));
    assign w_s2   = w_ovf1 ? (r_r1[RW-1] ? MINV : MAXV) : r_r1[OW-1:0];

    assign w_s2x  = {{(PW-OW){r_s2[OW-1]}}, r_s2};
    assign w_gx   = {(PW-16)'(0), r_gain2};
    assign w_p    = w_s2x * w_gx;
    assign w_pr   = w_p + RND2;
    assign w_qf   = w_pr[PW-1:GF];
    assign w_hi2  = w_qf[QW-1:OW-1];
    assign w_ovf2 = !((&w_hi2) || (~|w_hi2));
    assign w_q    = w_ovf2 ? (w_qf[QW-1] ? MINV : MAXV) : w_qf[OW-1:0];
    assign w_sat  = r_sat1 | w_ovf2;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_v1     <= 1'b0;
            r_r1     <= '0;
            r_gain1  <= '0;
            r_v2     <= 1'b0;
            r_s2     <= '0;
            r_sat1   <= 1'b0;
            r_gain2  <= '0;
            r_valid  <= 1'b0;
            r_sample <= '0;
            r_sat    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_v1    <= i_valid;
            r_r1    <= w_r1;
            r_gain1 <= i_gain;
            r_v2    <= r_v1;
            r_s2    <= w_s2;
            r_sat1  <= w_ovf1;
            r_gain2 <= r_gain1;
            r_valid <= r_v2;
            if (r_v2) begin
                r_sample <= w_q;
                r_sat    <= w_sat;
            end
            // Clear has priority over a simultaneous saturated sample.
            if (i_clr_sat)
                r_cnt <= '0;
            else if (r_v2 && w_sat && (r_cnt != 16'hFFFF))
                r_cnt <= r_cnt + 16'd1;
        end
    end

`ifdef ENVELOPE_EN
    logic [OW-1:0] r_env;
    logic [OW-1:0] w_abs;

    // |MINV| has no positive OW-bit representation, so it maps to MAXV.
    assign w_abs = (w_q == MINV) ? MAXV : (w_q[OW-1] ? (~w_q + OW'(1)) : w_q);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            r_env <= '0;
        else if (r_v2) begin
            if (w_abs > r_env)
                r_env <= r_env + ((w_abs - r_env) >> ENV_ATK);
            else
                r_env <= r_env - ((r_env - w_abs) >> ENV_REL);
        end
    end

    assign o_env = r_env;
`else
    assign o_env = '0;
`endif

    assign o_valid     = r_valid;
    assign o_sample    = r_sample;
    assign o_sat       = r_sat;
    assign o_sat_count = r_cnt;

endmodule

// File: tb/tb_fir_requant_gain.sv
// Directed bench for fir_requant_gain: arithmetic reference model compared every cycle,
// plus hand-computed literal checks. Envelope checks are built when ENVELOPE_EN is defined.
module tb_fir_requant_gain;

    logic        i_clk;
    logic        i_reset_n;
    logic        i_valid;
    logic [31:0] i_result;
    logic [15:0] i_gain;
    logic        i_clr_sat;
    logic        o_valid;
    logic [15:0] o_sample;
    logic        o_sat;
    logic [15:0] o_sat_count;
    logic [15:0] o_env;

    int n_tests = 0;
    int n_fail  = 0;

    fir_requant_gain dut (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_valid     (i_valid),
        .i_result    (i_result),
        .i_gain      (i_gain),
        .i_clr_sat   (i_clr_sat),
        .o_valid     (o_valid),
        .o_sample    (o_sample),
        .o_sat       (o_sat),
        .o_sat_count (o_sat_count),
        .o_env       (o_env)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: exact integer rounding/clamping on wide signed values.
    function automatic void model(input logic [31:0] res, input logic [15:0] g,
                                  output int q, output bit sat);
        longint r, p;
        r   = (longint'($signed(res)) + 64'sd16384) >>> 15;
        sat = 1'b0;
        if (r > 32767)       begin r = 32767;  sat = 1'b1; end
        else if (r < -32768) begin r = -32768; sat = 1'b1; end
        p = r * longint'({48'd0, g});
        p = (p + 64'sd2048) >>> 12;
        if (p > 32767)       begin p = 32767;  sat = 1'b1; end
        else if (p < -32768) begin p = -32768; sat = 1'b1; end
        q = int'(p);
    endfunction

    bit p0_v, p1_v, p0_s, p1_s;
    int p0_q, p1_q;
    bit exp_v, exp_sat;
    int exp_q, exp_cnt, exp_env;

    always @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            p0_v = 0; p1_v = 0; p0_s = 0; p1_s = 0; p0_q = 0; p1_q = 0;
            exp_v = 0; exp_sat = 0; exp_q = 0; exp_cnt = 0; exp_env = 0;
        end else begin
            int a;
            if (p1_v) begin
                exp_q   = p1_q;
                exp_sat = p1_s;
`ifdef ENVELOPE_EN
                a = (p1_q < 0) ? -p1_q : p1_q;
                if (a > 32767) a = 32767;
                if (a > exp_env) exp_env = exp_env + ((a - exp_env) >> 2);
                else             exp_env = exp_env - ((exp_env - a) >> 6);
`endif
            end
            if (i_clr_sat)                                 exp_cnt = 0;
            else if (p1_v && p1_s && exp_cnt != 16'hFFFF)  exp_cnt = exp_cnt + 1;
            exp_v = p1_v;
            p1_v = p0_v; p1_q = p0_q; p1_s = p0_s;
            p0_v = i_valid;
            model(i_result, i_gain, p0_q, p0_s);
        end
    end

    always @(negedge i_clk) begin
        if (i_reset_n) begin
            check("valid", o_valid, exp_v);
            check("sample", $signed(o_sample), exp_q);
            check("sat", o_sat, exp_sat);
            check("sat_count", o_sat_count, exp_cnt);
            check("env", o_env, exp_env);
        end
    end

    task automatic cyc(input bit v, input logic [31:0] res, input logic [15:0] g, input bit clr);
        @(posedge i_clk);
        #1;
        i_valid   = v;
        i_result  = res;
        i_gain    = g;
        i_clr_sat = clr;
    endtask

    // Sample driven by a cyc call is visible at the negedge after three further cyc calls.
    task automatic send_check(input string name, input logic [31:0] res, input logic [15:0] g,
                              input int es, input bit esat);
        cyc(1, res, g, 0);
        repeat (3) cyc(0, 0, 16'h1000, 0);
        @(negedge i_clk);
        check({name, "_valid"}, o_valid, 1);
        check({name, "_sample"}, $signed(o_sample), es);
        check({name, "_sat"}, o_sat, esat);
    endtask

    task automatic do_reset();
        i_reset_n = 1'b0;
        repeat (2) @(posedge i_clk);
        #1 i_reset_n = 1'b1;
    endtask

    bit pat[8] = '{1, 0, 1, 1, 0, 0, 0, 0};
    logic [15:0] galt[4] = '{16'h2000, 16'h0800, 16'h2000, 16'h0800};
    int qalt[4] = '{32767, 10000, 32767, 10000};
    bit salt[4] = '{1, 0, 1, 0};

    initial begin
        i_valid = 0; i_result = 0; i_gain = 16'h1000; i_clr_sat = 0;
        i_reset_n = 1'b0;
        #1;
        check("reset_valid", o_valid, 0);
        check("reset_sample", o_sample, 0);
        check("reset_count", o_sat_count, 0);
        check("reset_env", o_env, 0);
        do_reset();

        send_check("rnd_c000", 32'h0000C000, 16'h1000, 2, 0);
        send_check("rnd_ffffc000", 32'hFFFFC000, 16'h1000, 0, 0);
        send_check("rnd_4000", 32'h00004000, 16'h1000, 1, 0);

        send_check("insat_pos", 32'h7FFFFFFF, 16'h1000, 32767, 1);
        check("insat_pos_count", o_sat_count, 1);
        send_check("insat_neg", 32'h80000000, 16'h1000, -32768, 1);
        check("insat_neg_count", o_sat_count, 2);

        send_check("gain_x2", 32'd20000 << 15, 16'h2000, 32767, 1);
        send_check("gain_half", 32'd20000 << 15, 16'h0800, 10000, 0);

        for (int k = 0; k < 7; k++) begin
            if (k < 4) cyc(1, 32'd20000 << 15, galt[k], 0);
            else       cyc(0, 0, 16'h1000, 0);
            @(negedge i_clk);
            if (k >= 3) begin
                check("galt_sample", $signed(o_sample), qalt[k-3]);
                check("galt_sat", o_sat, salt[k-3]);
            end
        end

        for (int k = 0; k < 8; k++) begin
            cyc(pat[k], 32'h00010000, 16'h1000, 0);
            @(negedge i_clk);
            if (k >= 3) check("bubble_valid", o_valid, pat[k-3]);
        end

`ifdef ENVELOPE_EN
        do_reset();
        for (int k = 0; k < 7; k++) begin
            if (k < 3)       cyc(1, 32'd1024 << 15, 16'h1000, 0);
            else if (k == 3) cyc(1, 32'd0, 16'h1000, 0);
            else             cyc(0, 0, 16'h1000, 0);
            @(negedge i_clk);
            if (k == 3) check("env_1", o_env, 256);
            if (k == 4) check("env_2", o_env, 448);
            if (k == 5) check("env_3", o_env, 592);
            if (k == 6) check("env_decay", o_env, 583);
        end
`endif

        for (int k = 0; k < 65540; k++) cyc(1, 32'h7FFFFFFF, 16'h1000, 0);
        repeat (3) cyc(0, 0, 16'h1000, 0);
        @(negedge i_clk);
        check("count_stick", o_sat_count, 16'hFFFF);

        cyc(1, 32'h7FFFFFFF, 16'h1000, 0);
        cyc(0, 0, 16'h1000, 0);
        cyc(0, 0, 16'h1000, 1);
        cyc(0, 0, 16'h1000, 0);
        @(negedge i_clk);
        check("clr_win_valid", o_valid, 1);
        check("clr_win_sat", o_sat, 1);
        check("clr_win_count", o_sat_count, 0);

        send_check("pre_rst", 32'd300 << 15, 16'h1000, 300, 0);
        cyc(1, 32'd5 << 15, 16'h1000, 0);
        cyc(1, 32'h7FFFFFFF, 16'h1000, 0);
        cyc(0, 0, 16'h1000, 0);
        #2 i_reset_n = 1'b0;
        #1;
        check("rst_mid_valid", o_valid, 0);
        check("rst_mid_sample", o_sample, 0);
        check("rst_mid_sat", o_sat, 0);
        check("rst_mid_count", o_sat_count, 0);
        check("rst_mid_env", o_env, 0);
        #1 i_reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge i_clk);
            check("rst_after_valid", o_valid, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
